// File: rtl/branch_predict_ctrl.sv
// Branch predictor: direct-mapped table of 2-bit saturating counters with
// misprediction redirect/flush sequencing and saturating branch statistics.
module branch_predict_ctrl #(
   parameter int INDEX_W      = 6,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      if_pc,
   input  logic             if_is_branch,
   input  logic [31:0]      if_imm,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             id_valid,
   input  logic [6:0]       id_opcode,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      id_imm,
   input  logic             id_pred_taken,
   input  logic             exe_branch,
   input  logic             stall,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned DEPTH      = 2 ** INDEX_W;
   localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
   localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   typedef enum logic {ST_NORMAL, ST_FLUSH} state_t;

   state_t             state;
   logic [2:0]         fcnt;
   logic [1:0]         bht [DEPTH];
   logic [INDEX_W-1:0] if_idx;
   logic [INDEX_W-1:0] id_idx;
   logic               res;
   logic               mis;

   always_comb begin
      if_idx      = if_pc[INDEX_W+1:2];
      id_idx      = id_pc[INDEX_W+1:2];
      pred_taken  = if_is_branch & bht[if_idx][1];
      pred_target = if_pc + if_imm;
      res         = id_valid & ~stall & (id_opcode == OP_BRANCH) & (state == ST_NORMAL);
      mis         = res & (exe_branch != id_pred_taken);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) bht[i[INDEX_W-1:0]] <= 2'b01;
         state       <= ST_NORMAL;
         fcnt        <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         flush       <= 1'b0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (res) begin
            if (exe_branch) begin
               if (bht[id_idx] != 2'b11) bht[id_idx] <= bht[id_idx] + 2'b01;
            end else if (bht[id_idx] != 2'b00) begin
               bht[id_idx] <= bht[id_idx] - 2'b01;
            end
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (mis && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);

         case (state)
            ST_NORMAL: begin
               if (mis) begin
                  state       <= ST_FLUSH;
                  redirect    <= 1'b1;
                  flush       <= 1'b1;
                  fcnt        <= FLUSH_INIT;
                  redirect_pc <= exe_branch ? (id_pc + id_imm) : (id_pc + 32'd4);
               end
            end
            ST_FLUSH: begin
               // countdown ignores stall; ID is wrong-path until flush ends
               redirect <= 1'b0;
               if (fcnt == '0) begin
                  flush <= 1'b0;
                  state <= ST_NORMAL;
               end else begin
                  fcnt <= fcnt - 3'd1;
               end
            end
            default: state <= ST_NORMAL;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a cycle-level behavioural model
// and a per-cycle compare process, plus hand-computed literal checks.
module tb_branch_predict_ctrl;

   localparam int IW = 6;
   localparam int FC = 3;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   if_pc, if_imm, id_pc, id_imm;
   logic          if_is_branch, id_valid, id_pred_taken, exe_branch, stall;
   logic [6:0]    id_opcode;
   logic          pred_taken, redirect, flush;
   logic [31:0]   pred_target, redirect_pc;
   logic [CW-1:0] branch_cnt, mispred_cnt;

   int compared   = 0;
   int mismatched = 0;

   branch_predict_ctrl #(.INDEX_W(IW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_pc(if_pc), .if_is_branch(if_is_branch), .if_imm(if_imm),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc), .id_imm(id_imm),
      .id_pred_taken(id_pred_taken), .exe_branch(exe_branch), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: counters as plain ints, flush as remaining-cycles count.
   int          m_tab [1 << IW];
   int          m_left;
   bit          m_redir;
   logic [31:0] m_rpc;
   int          m_bc, m_mc;

   always @(posedge clk or negedge rst_n) begin : model
      int idx;
      bit is_res;
      if (!rst_n) begin
         for (int i = 0; i < (1 << IW); i++) m_tab[i] <= 1;
         m_left  <= 0;
         m_redir <= 0;
         m_rpc   <= '0;
         m_bc    <= 0;
         m_mc    <= 0;
      end else begin
         is_res = id_valid && !stall && id_opcode == 7'h63 && m_left == 0;
         idx = int'(id_pc >> 2) % (1 << IW);
         m_redir <= 0;
         if (m_left > 0) m_left <= m_left - 1;
         if (is_res) begin
            if (exe_branch) m_tab[idx] <= (m_tab[idx] < 3) ? m_tab[idx] + 1 : 3;
            else            m_tab[idx] <= (m_tab[idx] > 0) ? m_tab[idx] - 1 : 0;
            m_bc <= (m_bc < CMAX) ? m_bc + 1 : CMAX;
            if (exe_branch != id_pred_taken) begin
               m_mc    <= (m_mc < CMAX) ? m_mc + 1 : CMAX;
               m_left  <= FC;
               m_redir <= 1;
               m_rpc   <= exe_branch ? id_pc + id_imm : id_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int idx;
      if (rst_n) begin
         idx = int'(if_pc >> 2) % (1 << IW);
         chk("pred_taken", {31'b0, pred_taken}, {31'b0, if_is_branch && m_tab[idx] >= 2});
         chk("pred_target", pred_target, if_pc + if_imm);
         chk("redirect", {31'b0, redirect}, {31'b0, m_redir});
         if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
         chk("flush", {31'b0, flush}, {31'b0, m_left > 0});
         chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
         chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_id();
      id_valid = 0; id_opcode = 7'h13; stall = 0;
   endtask

   task automatic present(input logic [31:0] pc, input logic [31:0] imm, input logic pred, input logic outcome);
      id_valid = 1; id_opcode = 7'h63; id_pc = pc; id_imm = imm;
      id_pred_taken = pred; exe_branch = outcome; stall = 0;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] imm, input logic pred, input logic outcome);
      present(pc, imm, pred, outcome);
      cyc();
      idle_id();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 0;
      if_pc = 0; if_imm = 0; if_is_branch = 0;
      id_pc = 0; id_imm = 0; id_pred_taken = 0; exe_branch = 0;
      idle_id();
      repeat (3) cyc();
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
      rst_n = 1;

      if_pc = 32'h100; if_is_branch = 1; if_imm = 32'hFFFF_FFF0;
      #1;
      chk("lit_pred0", {31'b0, pred_taken}, 32'd0);
      chk("lit_target", pred_target, 32'h0000_00F0);
      cyc();

      // first mispredict, then a wrong-path branch in ID during flush
      resolve(32'h100, 32'h20, 0, 1);
      chk("lit_redir", {31'b0, redirect}, 32'd1);
      chk("lit_rpc_taken", redirect_pc, 32'h120);
      chk("lit_bc1", 32'(branch_cnt), 32'd1);
      chk("lit_mc1", 32'(mispred_cnt), 32'd1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (flush) n++;
         if (i < 3) present(32'h200, 32'h40, 0, 1); else idle_id();
         cyc();
      end
      chk("lit_flush_len", 32'(n), 32'(FC));
      chk("lit_bc_flushbr", 32'(branch_cnt), 32'd1);

      // train to saturation, then a not-taken mispredict
      for (int i = 0; i < 3; i++) begin
         resolve(32'h100, 32'h20, 1, 1);
         chk("lit_no_redir", {31'b0, redirect}, 32'd0);
      end
      if_pc = 32'h100;
      #1;
      chk("lit_pred_sat", {31'b0, pred_taken}, 32'd1);
      resolve(32'h100, 32'h20, 1, 0);
      chk("lit_rpc_nt", redirect_pc, 32'h104);
      repeat (4) cyc();

      // stalled mispredict resolves exactly once after stall drops
      present(32'h108, 32'h40, 0, 1);
      stall = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("lit_stall_noredir", {31'b0, redirect}, 32'd0);
      end
      stall = 0;
      cyc();
      idle_id();
      chk("lit_stall_redir", {31'b0, redirect}, 32'd1);
      chk("lit_stall_rpc", redirect_pc, 32'h148);
      n = 0;
      repeat (5) begin
         cyc();
         if (redirect) n++;
      end
      chk("lit_stall_once", 32'(n), 32'd0);
      chk("lit_bc6", 32'(branch_cnt), 32'd6);
      chk("lit_mc3", 32'(mispred_cnt), 32'd3);

      // same-index read and train: prediction sees the old entry
      if_pc = 32'h10C; if_is_branch = 1;
      present(32'h10C, 32'h0, 1, 1);
      #3;
      chk("lit_same_old", {31'b0, pred_taken}, 32'd0);
      cyc();
      idle_id();
      chk("lit_same_new", {31'b0, pred_taken}, 32'd1);

      // drive both counters into saturation
      repeat (16) begin
         resolve(32'h110, 32'h8, 1, 0);
         repeat (3) cyc();
      end
      chk("lit_mc_sat", 32'(mispred_cnt), 32'(CMAX));
      chk("lit_bc_sat", 32'(branch_cnt), 32'(CMAX));
      resolve(32'h110, 32'h8, 1, 0);
      repeat (3) cyc();
      chk("lit_mc_hold", 32'(mispred_cnt), 32'(CMAX));

      // reset asserted mid-flush
      resolve(32'h110, 32'h8, 1, 0);
      chk("lit_preflush", {31'b0, flush}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("lit_rst_flush", {31'b0, flush}, 32'd0);
      chk("lit_rst_redir", {31'b0, redirect}, 32'd0);
      chk("lit_rst_mc", 32'(mispred_cnt), 32'd0);
      if_pc = 32'h10C;
      #1;
      chk("lit_rst_table", {31'b0, pred_taken}, 32'd0);
      cyc();
      rst_n = 1;
      repeat (3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
